// File: rtl/raster_stream_rx.sv
// Receive end of the raster pixel/depth stream: rebuilds x/y indices and frame
// pulses from a valid-qualified stream with blanking gaps, and flags bad line lengths.
module raster_stream_rx #(
   parameter int H_SIZE_BW     = 10,
   parameter int V_SIZE_BW     = 9,
   parameter int DATA_RGB_BW   = 8,
   parameter int DATA_DEPTH_BW = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_frame_start,
   input  logic                     i_valid,
   input  logic [DATA_RGB_BW-1:0]   i_data,
   input  logic [DATA_DEPTH_BW-1:0] i_depth,
   input  logic [H_SIZE_BW-1:0]     r_hsize,
   input  logic [V_SIZE_BW-1:0]     r_vsize,
   output logic                     o_frame_start,
   output logic                     o_frame_end,
   output logic                     o_valid,
   output logic [DATA_RGB_BW-1:0]   o_data,
   output logic [DATA_DEPTH_BW-1:0] o_depth,
   output logic [H_SIZE_BW-1:0]     o_idx_x,
   output logic [V_SIZE_BW-1:0]     o_idx_y,
   output logic                     o_line_end,
   output logic                     o_err_short_line,
   output logic                     o_err_long_line,
   output logic                     o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_END    = 2'd3
   } state_t;

   localparam logic [H_SIZE_BW-1:0] H_ZERO = {H_SIZE_BW{1'b0}};
   localparam logic [H_SIZE_BW-1:0] H_ONE  = H_SIZE_BW'(1);
   localparam logic [V_SIZE_BW-1:0] V_ZERO = {V_SIZE_BW{1'b0}};
   localparam logic [V_SIZE_BW-1:0] V_ONE  = V_SIZE_BW'(1);

   state_t               state;
   state_t               state_nxt;
   logic [H_SIZE_BW-1:0] x;
   logic [H_SIZE_BW-1:0] x_nxt;
   logic [V_SIZE_BW-1:0] y;
   logic [V_SIZE_BW-1:0] y_nxt;
   logic                 prev_v;
   logic                 gap;
   logic                 x_in_line;
   logic                 last_col;
   logic                 last_row;
   logic                 emit;
   logic                 emit_first;
   logic                 emit_last;
   logic                 set_short;
   logic                 set_long;
   logic                 clr_err;
   logic                 frame_end_nxt;

   assign gap       = ~i_valid & prev_v;
   assign x_in_line = (x < r_hsize);
   assign last_col  = (x == (r_hsize - H_ONE));
   assign last_row  = (y == (r_vsize - V_ONE));

   // State register, position counters and blanking-gap detector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         x      <= H_ZERO;
         y      <= V_ZERO;
         prev_v <= 1'b0;
      end else begin
         state  <= state_nxt;
         x      <= x_nxt;
         y      <= y_nxt;
         prev_v <= i_valid;
      end
   end

   // Next-state and per-cycle event decode
   always_comb begin
      state_nxt     = state;
      x_nxt         = x;
      y_nxt         = y;
      emit          = 1'b0;
      emit_first    = 1'b0;
      emit_last     = 1'b0;
      set_short     = 1'b0;
      set_long      = 1'b0;
      clr_err       = 1'b0;
      frame_end_nxt = 1'b0;
      if (i_frame_start) begin
         // arm or restart; a pixel on this cycle is deliberately discarded
         state_nxt = ST_ARMED;
         x_nxt     = H_ZERO;
         y_nxt     = V_ZERO;
         clr_err   = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_IDLE;
            end
            ST_ARMED: begin
               if (i_valid) begin
                  emit       = 1'b1;
                  emit_first = 1'b1;
                  x_nxt      = H_ONE;
                  state_nxt  = ST_ACTIVE;
               end else begin
                  state_nxt = ST_ARMED;
               end
            end
            ST_ACTIVE: begin
               if (i_valid) begin
                  if (x_in_line) begin
                     emit      = 1'b1;
                     emit_last = last_col;
                     x_nxt     = x + H_ONE;
                     if (last_col && last_row) begin
                        state_nxt = ST_END;
                     end else begin
                        state_nxt = ST_ACTIVE;
                     end
                  end else begin
                     // excess pixel: dropped, x stays saturated at r_hsize
                     set_long = 1'b1;
                     x_nxt    = x;
                  end
               end else if (gap) begin
                  if (x_in_line) begin
                     set_short = 1'b1;
                     if (last_row) begin
                        state_nxt = ST_END;
                     end else begin
                        y_nxt = y + V_ONE;
                        x_nxt = H_ZERO;
                     end
                  end else begin
                     y_nxt = y + V_ONE;
                     x_nxt = H_ZERO;
                  end
               end else begin
                  state_nxt = ST_ACTIVE;
               end
            end
            ST_END: begin
               frame_end_nxt = 1'b1;
               state_nxt     = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Registered outputs: pulses, captured pixel, sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_frame_start    <= 1'b0;
         o_frame_end      <= 1'b0;
         o_valid          <= 1'b0;
         o_data           <= {DATA_RGB_BW{1'b0}};
         o_depth          <= {DATA_DEPTH_BW{1'b0}};
         o_idx_x          <= H_ZERO;
         o_idx_y          <= V_ZERO;
         o_line_end       <= 1'b0;
         o_err_short_line <= 1'b0;
         o_err_long_line  <= 1'b0;
         o_busy           <= 1'b0;
      end else begin
         o_frame_start <= emit_first;
         o_frame_end   <= frame_end_nxt;
         o_valid       <= emit;
         o_line_end    <= emit_last;
         o_busy        <= (state_nxt != ST_IDLE);
         if (emit) begin
            o_data  <= i_data;
            o_depth <= i_depth;
            o_idx_x <= x;
            o_idx_y <= y;
         end else begin
            o_data  <= o_data;
            o_depth <= o_depth;
            o_idx_x <= o_idx_x;
            o_idx_y <= o_idx_y;
         end
         if (clr_err) begin
            o_err_short_line <= 1'b0;
            o_err_long_line  <= 1'b0;
         end else begin
            o_err_short_line <= o_err_short_line | set_short;
            o_err_long_line  <= o_err_long_line | set_long;
         end
      end
   end

endmodule

// File: tb/tb_raster_stream_rx.sv
// Scoreboard bench for raster_stream_rx: a frame-level model pushes expected pixels
// and frame-end events; a negedge monitor pops and compares whatever the DUT emits.
`timescale 1ns/1ps
module tb_raster_stream_rx;
   localparam int HB = 10;
   localparam int VB = 9;
   localparam int DB = 8;
   localparam int ZB = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_frame_start = 1'b0;
   logic          i_valid = 1'b0;
   logic [DB-1:0] i_data = '0;
   logic [ZB-1:0] i_depth = '0;
   logic [HB-1:0] r_hsize = 10'd4;
   logic [VB-1:0] r_vsize = 9'd3;
   logic          o_frame_start, o_frame_end, o_valid, o_line_end;
   logic [DB-1:0] o_data;
   logic [ZB-1:0] o_depth;
   logic [HB-1:0] o_idx_x;
   logic [VB-1:0] o_idx_y;
   logic          o_err_short_line, o_err_long_line, o_busy;

   raster_stream_rx dut (
      .clk(clk), .rst_n(rst_n), .i_frame_start(i_frame_start), .i_valid(i_valid),
      .i_data(i_data), .i_depth(i_depth), .r_hsize(r_hsize), .r_vsize(r_vsize),
      .o_frame_start(o_frame_start), .o_frame_end(o_frame_end), .o_valid(o_valid),
      .o_data(o_data), .o_depth(o_depth), .o_idx_x(o_idx_x), .o_idx_y(o_idx_y),
      .o_line_end(o_line_end), .o_err_short_line(o_err_short_line),
      .o_err_long_line(o_err_long_line), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_end;
      int x;
      int y;
      int d;
      int z;
      bit fs;
      bit le;
      int delta;
   } ev_t;

   ev_t exp_q[$];
   int  lq[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  last_valid_cyc = 0;
   int  hold_d = 0;
   int  hold_z = 0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // monitor: pop one expected event per DUT output event
   always @(negedge clk) begin
      ev_t e;
      bit  avail;
      cyc++;
      if (!rst_n) begin
         hold_d = 0;
         hold_z = 0;
      end
      if (o_valid) begin
         avail = (exp_q.size() != 0) && !exp_q[0].is_end;
         check("pixel_expected", avail, 1);
         if (avail) begin
            e = exp_q.pop_front();
            check("idx_x", o_idx_x, e.x);
            check("idx_y", o_idx_y, e.y);
            check("data", o_data, e.d);
            check("depth", o_depth, e.z);
            check("frame_start", o_frame_start, e.fs);
            check("line_end", o_line_end, e.le);
            hold_d = e.d;
            hold_z = e.z;
            last_valid_cyc = cyc;
         end
      end else begin
         check("data_hold", o_data, hold_d);
         check("depth_hold", o_depth, hold_z);
         check("stray_pulse", {o_frame_start, o_line_end}, 0);
      end
      if (o_frame_end) begin
         avail = (exp_q.size() != 0) && exp_q[0].is_end;
         check("frame_end_expected", avail, 1);
         if (avail) begin
            e = exp_q.pop_front();
            check("frame_end_delay", cyc - last_valid_cyc, e.delta);
         end
      end
   end

   task automatic drive(input bit fs, input bit v, input int d, input int z);
      i_frame_start = fs;
      i_valid       = v;
      i_data        = DB'(d);
      i_depth       = ZB'(z);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_line_lens(input int h, input int v);
      lq = {};
      for (int r = 0; r < v; r++) begin
         if ($urandom_range(0, 9) < 7) lq.push_back(h);
         else lq.push_back($urandom_range(1, h + 3));
      end
   endtask

   task automatic lens3(input int a, input int b, input int c);
      lq = {};
      if (a > 0) lq.push_back(a);
      if (b > 0) lq.push_back(b);
      if (c > 0) lq.push_back(c);
   endtask

   // one frame: model pushes expectations from line lengths, then the rows are driven
   task automatic do_frame(input int h, input int v, input int blank, input bit tail_blank);
      int dq[$];
      int zq[$];
      int n = 0;
      int p = 0;
      bit done = 0;
      bit full_last = 0;
      bit es = 0;
      bit el = 0;
      ev_t e;
      r_hsize = HB'(h);
      r_vsize = VB'(v);
      foreach (lq[i]) n += lq[i];
      for (int i = 0; i < n; i++) begin
         dq.push_back($urandom_range(0, 255));
         zq.push_back($urandom_range(0, 65535));
      end
      for (int r = 0; r < lq.size() && !done; r++) begin
         for (int k = 0; k < lq[r] && !done; k++) begin
            if (k < h) begin
               e = '{is_end: 0, x: k, y: r, d: dq[p], z: zq[p],
                     fs: (r == 0 && k == 0), le: (k == h - 1), delta: 0};
               exp_q.push_back(e);
               if (r == v - 1 && k == h - 1) begin
                  done = 1;
                  full_last = 1;
               end
            end else begin
               el = 1;
            end
            p++;
         end
         if (!done && (r < lq.size() - 1 || tail_blank)) begin
            if (lq[r] < h) es = 1;
            if (r == v - 1) done = 1;
         end
      end
      if (done) begin
         e = '{is_end: 1, x: 0, y: 0, d: 0, z: 0, fs: 0, le: 0, delta: (full_last ? 1 : 2)};
         exp_q.push_back(e);
      end
      drive(1, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 65535));
      check("armed_busy", o_busy, 1);
      check("armed_err_short", o_err_short_line, 0);
      check("armed_err_long", o_err_long_line, 0);
      p = 0;
      foreach (lq[r]) begin
         for (int k = 0; k < lq[r]; k++) begin
            drive(0, 1, dq[p], zq[p]);
            p++;
         end
         if (r < lq.size() - 1 || tail_blank)
            for (int b = 0; b < blank; b++) drive(0, 0, 0, 0);
      end
      if (done) begin
         for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
         for (int i = 0; i < 6; i++) drive(0, $urandom_range(0, 1), $urandom_range(0, 255), 0);
         for (int i = 0; i < 2; i++) drive(0, 0, 0, 0);
         check("done_busy", o_busy, 0);
      end else begin
         check("open_busy", o_busy, 1);
      end
      check("err_short", o_err_short_line, es);
      check("err_long", o_err_long_line, el);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", o_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_pulses", {o_frame_start, o_frame_end, o_line_end}, 0);
      check("rst_errs", {o_err_short_line, o_err_long_line}, 0);
      check("rst_idx", {o_idx_x, o_idx_y}, 0);
      check("rst_data", {o_data, o_depth}, 0);
      rst_n = 1'b1;
      drive(0, 0, 0, 0);

      // valid activity with no frame armed
      for (int i = 0; i < 20; i++) drive(0, $urandom_range(0, 1), $urandom_range(0, 255), 7);
      check("unarmed_busy", o_busy, 0);

      lens3(4, 4, 4); do_frame(4, 3, 2, 1);
      lens3(4, 3, 4); do_frame(4, 3, 2, 1);
      lens3(6, 4, 4); do_frame(4, 3, 2, 1);
      lens3(4, 4, 2); do_frame(4, 3, 2, 1);
      lens3(4, 4, 6); do_frame(4, 3, 1, 1);
      lens3(2, 2, 0); do_frame(2, 2, 1, 1);
      lens3(1, 2, 0); do_frame(2, 2, 3, 1);

      // restart mid-frame after errors, then a clean frame
      lens3(6, 1, 0); do_frame(4, 3, 2, 1);
      lens3(4, 4, 4); do_frame(4, 3, 2, 1);
      // restart mid-line with no gap
      lens3(4, 1, 0); do_frame(4, 3, 2, 0);
      lens3(4, 4, 4); do_frame(4, 3, 2, 1);

      // async reset in the middle of row 1
      lens3(5, 2, 0); do_frame(4, 3, 2, 0);
      @(negedge clk);
      #1;
      rst_n   = 1'b0;
      i_valid = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_valid", o_valid, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_errs", {o_err_short_line, o_err_long_line}, 0);
      check("midrst_outs", {o_idx_x, o_idx_y, o_data, o_depth}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) drive(0, $urandom_range(0, 1), $urandom_range(0, 255), 3);
      check("postrst_busy", o_busy, 0);

      for (int f = 0; f < 15; f++) begin
         int h;
         int v;
         h = $urandom_range(2, 12);
         v = $urandom_range(2, 8);
         rand_line_lens(h, v);
         do_frame(h, v, $urandom_range(1, 4), 1);
      end

      rand_line_lens(640, 8);
      do_frame(640, 8, 64, 1);
      lq = {};
      for (int r = 0; r < 480; r++) lq.push_back(4);
      do_frame(4, 480, 2, 1);

      repeat (4) drive(0, 0, 0, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
